// File: rtl/mvm_mac_engine_if.sv
// Start/busy handshake bundle between the vector sequencer (master) and the MAC engine (slave).
interface mvm_mac_engine_if #(
  parameter int NUM_BIT = 16,
  parameter int NUM_DIM = 8
);
  logic                              i_start_mac;
  logic                              i_clr_mac;
  logic [NUM_DIM-1:0][NUM_BIT-1:0]   i_x_mac;
  logic [NUM_BIT-1:0]                i_w_mac;
  logic                              o_busy_mac;
  logic                              o_done_mac;
  logic [NUM_DIM-1:0][NUM_BIT-1:0]   o_result_mac;

  modport master (
    output i_start_mac, i_clr_mac, i_x_mac, i_w_mac,
    input  o_busy_mac, o_done_mac, o_result_mac
  );

  modport slave (
    input  i_start_mac, i_clr_mac, i_x_mac, i_w_mac,
    output o_busy_mac, o_done_mac, o_result_mac
  );
endinterface

// File: rtl/mvm_mac_engine.sv
// Scalar-times-vector accumulate engine, LANES elements per cycle, persistent accumulators.
// Define MAC_SAT_EN for saturating accumulation; otherwise accumulation wraps two's complement.
module mvm_mac_engine #(
  parameter int NUM_BIT   = 16,
  parameter int NUM_DIM   = 8,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 2
) (
  input  logic              i_clk_mac,
  input  logic              i_rst_mac,
  mvm_mac_engine_if.slave   bus
);

  localparam int IDXW = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [IDXW-1:0]                  idx_q;
  logic [NUM_DIM-1:0][NUM_BIT-1:0]  x_q;
  logic signed [NUM_BIT-1:0]        w_q;
  logic [NUM_DIM-1:0][NUM_BIT-1:0]  acc_q;
  logic [LANES-1:0][NUM_BIT-1:0]    lane_sum;
  logic                             last_beat;

`ifdef MAC_SAT_EN
  localparam logic signed [2*NUM_BIT-1:0] MAX_W = {{(NUM_BIT+1){1'b0}}, {(NUM_BIT-1){1'b1}}};
  localparam logic signed [2*NUM_BIT-1:0] MIN_W = ~MAX_W;

  function automatic logic signed [NUM_BIT-1:0] sat_word(input logic signed [2*NUM_BIT-1:0] v);
    if (v > MAX_W)      return {1'b0, {(NUM_BIT-1){1'b1}}};
    else if (v < MIN_W) return {1'b1, {(NUM_BIT-1){1'b0}}};
    else                return v[NUM_BIT-1:0];
  endfunction

  // One guard bit is enough: a disagreement between the top two bits means overflow.
  function automatic logic signed [NUM_BIT-1:0] sat_add(input logic signed [NUM_BIT-1:0] a,
                                                        input logic signed [NUM_BIT-1:0] b);
    logic signed [NUM_BIT:0] s;
    s = {a[NUM_BIT-1], a} + {b[NUM_BIT-1], b};
    if (s[NUM_BIT] != s[NUM_BIT-1])
      return s[NUM_BIT] ? {1'b1, {(NUM_BIT-1){1'b0}}} : {1'b0, {(NUM_BIT-1){1'b1}}};
    else
      return s[NUM_BIT-1:0];
  endfunction
`endif

  function automatic logic signed [NUM_BIT-1:0] mac_lane(input logic signed [NUM_BIT-1:0] acc,
                                                         input logic signed [NUM_BIT-1:0] x,
                                                         input logic signed [NUM_BIT-1:0] w);
    logic signed [2*NUM_BIT-1:0] p;
    p = x * w;
`ifdef MAC_SAT_EN
    return sat_add(acc, sat_word(p >>> FRAC_BITS));
`else
    return acc + NUM_BIT'(p >>> FRAC_BITS);
`endif
  endfunction

  assign last_beat = (idx_q == IDXW'(NUM_DIM - LANES));

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++)
      lane_sum[k] = mac_lane(acc_q[idx_q + IDXW'(k)], x_q[idx_q + IDXW'(k)], w_q);
  end

  always_ff @(posedge i_clk_mac or posedge i_rst_mac) begin
    if (i_rst_mac) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_start_mac) state_d = S_BUSY;
      S_BUSY:  if (last_beat)       state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Busy includes the raw start so the sequencer sees the ack in its request cycle.
  always_comb begin
    bus.o_done_mac = (state_q == S_DONE);
    bus.o_busy_mac = (state_q != S_IDLE) | ((state_q == S_IDLE) & bus.i_start_mac);
  end

  // Clear is applied before the latch so a combined clr+start accumulates onto zero.
  always_ff @(posedge i_clk_mac or posedge i_rst_mac) begin
    if (i_rst_mac) begin
      idx_q <= '0;
      x_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_clr_mac) acc_q <= '0;
          if (bus.i_start_mac) begin
            x_q   <= bus.i_x_mac;
            w_q   <= bus.i_w_mac;
            idx_q <= '0;
          end
        end
        S_BUSY: begin
          for (int k = 0; k < LANES; k++)
            acc_q[idx_q + IDXW'(k)] <= lane_sum[k];
          idx_q <= idx_q + IDXW'(LANES);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_result_mac = acc_q;

endmodule
